// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared constants, state encoding and request decoding for the load/store unit.
package load_store_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } lsu_state_t;

  // Illegal width code or an address not aligned to the access width.
  function automatic logic req_is_err(input logic [2:0] f3, input logic st, input logic [1:0] a);
    logic ill;
    logic mis;
    ill = st ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return ill || mis;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: extracts and extends a load lane from a word, and merges store data into a word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_addr,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_merged
);

  logic [4:0]      w_sh;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_mask;

  always_comb begin
    w_sh     = (i_funct3[1:0] == 2'b01) ? {i_addr[1], 4'b0000} : {i_addr, 3'b000};
    w_lane   = i_word >> w_sh;
    w_mask   = (i_funct3[1:0] == 2'b00) ? 32'h0000_00FF :
               (i_funct3[1:0] == 2'b01) ? 32'h0000_FFFF : '1;
    // funct3[2] selects zero extension for the unsigned loads
    o_load   = (i_funct3[1:0] == 2'b00) ? {{24{w_lane[7] & ~i_funct3[2]}}, w_lane[7:0]} :
               (i_funct3[1:0] == 2'b01) ? {{16{w_lane[15] & ~i_funct3[2]}}, w_lane[15:0]} : w_lane;
    o_merged = (i_word & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer with read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_store,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t      r_state;
  lsu_state_t      w_next;
  logic [2:0]      r_f3;
  logic            r_store;
  logic            r_err;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_word;
  logic            w_accept;
  logic            w_req_err;
  logic            w_sw;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_merged;

  assign w_accept  = req_valid && req_ready;
  assign w_req_err = req_is_err(req_funct3, req_store, req_addr[1:0]);
  assign w_sw      = r_store && r_f3 == F3_W;

  lsu_lane_align u_align (
    .i_word   (r_word),
    .i_addr   (r_addr[1:0]),
    .i_funct3 (r_f3),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_f3    <= '0;
      r_store <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_f3    <= req_funct3;
        r_store <= req_store;
        r_err   <= w_req_err;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_ACCESS) r_word <= mem_rd;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_accept ? (w_req_err ? S_RESP : S_ACCESS) : S_IDLE;
      S_ACCESS: w_next = (r_store && !w_sw) ? S_WRITE : S_RESP;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs decode from the state register so reset clears them without a clock.
  always_comb begin
    req_ready  = r_state == S_IDLE;
    resp_valid = r_state == S_RESP;
    resp_err   = resp_valid && r_err;
    resp_rdata = (resp_valid && !r_store && !r_err) ? w_load : '0;
    mem_we     = (r_state == S_ACCESS && w_sw) || r_state == S_WRITE;
    mem_a      = (r_state == S_ACCESS || r_state == S_WRITE) ? {r_addr[XLEN-1:2], 2'b00} : '0;
    mem_wd     = (r_state == S_ACCESS && w_sw) ? r_wdata : (r_state == S_WRITE) ? w_merged : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit against a behavioural word memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  logic        clk = 0;
  logic        rst = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 0;
  logic        req_store = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  typedef struct {
    logic [31:0] rd;
    logic [31:0] alt;
    logic        err;
    int          lat;
    int          we;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   nresp = 0;
  bit   busy = 0;
  int   lat = 0;
  int   wec = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_store  (req_store),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );
  always #5 clk = ~clk;
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) busy = 0;
      else if (req_valid && req_ready) begin busy = 1; lat = 1; wec = 0; end
      else if (busy) lat++;
      @(negedge clk);
      if (!rst) begin
        if (mem_we) wec++;
        else chk("wd_when_no_we", mem_wd, 32'h0);
        chk("mem_a_align", mem_a[1:0], 2'b00);
        if (busy) chk("ready_while_busy", req_ready, 1'b0);
        if (resp_valid) begin
          nresp++;
          if (q.size() == 0) chk("spurious_resp", resp_valid, 1'b0);
          else begin
            e = q.pop_front();
            if (e.alt !== e.rd) chk("rdata_either", (resp_rdata === e.rd) || (resp_rdata === e.alt), 1'b1);
            else chk("rdata", resp_rdata, e.rd);
            chk("err", resp_err, e.err);
            chk("latency", lat, e.lat);
            chk("we_cycles", wec, e.we);
          end
          busy = 0;
        end
      end
    end
  end
  task automatic model(input logic [2:0] f3, input logic st, input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    logic        ill, mis;
    logic [31:0] w, v, m;
    int          sh;
    ill = st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    e.err = ill || mis;
    e.rd = 0;
    e.we = 0;
    e.lat = 1;
    if (!e.err) begin
      w = shadow[a[9:2]];
      sh = 8 * a[1:0];
      v = w >> sh;
      e.lat = (st && f3 != 3'd2) ? 3 : 2;
      if (st) begin
        e.we = 1;
        m = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        shadow[a[9:2]] = (w & ~(m << sh)) | ((wd & m) << sh);
      end else begin
        case (f3)
          3'd0:    e.rd = {{24{v[7]}}, v[7:0]};
          3'd4:    e.rd = {24'h0, v[7:0]};
          3'd1:    e.rd = {{16{v[15]}}, v[15:0]};
          3'd5:    e.rd = {16'h0, v[15:0]};
          default: e.rd = w;
        endcase
      end
    end
    e.alt = e.rd;
  endtask
  task automatic issue(input logic [2:0] f3, input logic st, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, input bit use_k, input logic [31:0] k);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", req_ready, 1'b1);
    model(f3, st, a, wd, e);
    if (use_k) begin e.rd = k; e.alt = k; end
    q.push_back(e);
    req_valid = 1; req_funct3 = f3; req_store = st; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = hold; req_funct3 = 3'($urandom); req_store = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); #1; n++; end while ((q.size() != 0 || !req_ready) && n < 100);
    if (n >= 100) chk("drain_timeout", q.size(), 0);
  endtask
  initial begin
    logic [31:0] orig;
    int          n;
    int          base;
    for (int i = 0; i < 256; i++) begin mem[i] = 0; shadow[i] = 0; end
    #2 rst = 1;
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_a", mem_a, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    repeat (2) @(negedge clk);
    rst = 0;
    issue(F3_W, 1, 32'h00, 32'hA5A5A5A5, 0, 0, 0);
    issue(F3_W, 0, 32'h00, 0, 0, 1, 32'hA5A5A5A5);
    wait_idle();
    issue(F3_W, 1, 32'h04, 32'hABCDEF78, 0, 0, 0);
    issue(F3_B, 1, 32'h05, 32'h00000012, 0, 0, 0);
    wait_idle();
    chk("sb_merge_mem", mem[1], 32'hABCD1278);
    issue(F3_B, 0, 32'h05, 0, 0, 1, 32'h00000012);
    issue(F3_BU, 0, 32'h07, 0, 0, 1, 32'h000000AB);
    issue(F3_B, 0, 32'h07, 0, 0, 1, 32'hFFFFFFAB);
    issue(F3_W, 1, 32'h50, 32'h12128012, 0, 0, 0);
    issue(F3_H, 0, 32'h50, 0, 0, 1, 32'hFFFF8012);
    issue(F3_HU, 0, 32'h50, 0, 0, 1, 32'h00008012);
    issue(F3_H, 0, 32'h52, 0, 0, 1, 32'h00001212);
    issue(F3_H, 1, 32'h52, 32'hFFFF9876, 0, 0, 0);
    wait_idle();
    chk("sh_merge_mem", mem[20], 32'h98768012);
    issue(F3_W, 0, 32'h1023, 0, 0, 1, 32'h0);
    issue(F3_H, 1, 32'h51, 32'h1234, 0, 1, 32'h0);
    issue(3'b011, 0, 32'h00, 0, 0, 1, 32'h0);
    issue(3'b110, 0, 32'h00, 0, 0, 1, 32'h0);
    issue(3'b100, 1, 32'h00, 32'hDEADBEEF, 0, 1, 32'h0);
    wait_idle();
    chk("err_no_write", mem[0], 32'hA5A5A5A5);
    orig = shadow[1];
    issue(F3_B, 1, 32'h05, 32'h00000034, 0, 0, 0);
    n = 0;
    while (!mem_we && n < 10) begin @(negedge clk); n++; end
    chk("we_in_write", mem_we, 1'b1);
    rst = 1;
    #1;
    chk("midrst_we", mem_we, 1'b0);
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_resp", resp_valid, 1'b0);
    chk("midrst_wd", mem_wd, 32'h0);
    q.delete();
    @(negedge clk);
    rst = 0;
    chk("midrst_mem_whole", (mem[1] === orig) || (mem[1] === shadow[1]), 1'b1);
    issue(F3_W, 0, 32'h04, 0, 0, 0, 0);
    q[q.size() - 1].alt = orig;
    wait_idle();
    shadow[1] = mem[1];
    base = nresp;
    issue(F3_W, 1, 32'h100, $urandom, 1, 0, 0);
    issue(F3_B, 1, 32'h101, $urandom, 1, 0, 0);
    issue(F3_H, 1, 32'h102, $urandom, 1, 0, 0);
    issue(F3_W, 0, 32'h100, 0, 1, 0, 0);
    issue(F3_B, 0, 32'h103, 0, 1, 0, 0);
    issue(F3_HU, 0, 32'h102, 0, 1, 0, 0);
    issue(F3_W, 0, 32'h102, 0, 1, 0, 0);
    issue(F3_BU, 0, 32'h101, 0, 0, 0, 0);
    wait_idle();
    chk("b2b_resp_count", nresp - base, 8);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
